// File: rtl/interval_countdown_if.sv
// interval_countdown_if: bundles the controller/parameter-store handshake
// seen by interval_countdown. The slave modport is the timer itself; the
// master modport is whoever drives start/abort and returns the stored value.
// The pause signal exists only when TIMER_PAUSE_EN is defined.
interface interval_countdown_if #(
    parameter int VALUE_W = 4
);
    logic               start_timer;
    logic [1:0]         interval_req;
    logic               prog_sync;
    logic [VALUE_W-1:0] value;
`ifdef TIMER_PAUSE_EN
    logic               pause;
`endif
    logic [1:0]         interval_code;
    logic [VALUE_W-1:0] remaining;
    logic               busy;
    logic               expired;

    modport slave (
        input  start_timer, interval_req, prog_sync, value,
`ifdef TIMER_PAUSE_EN
        input  pause,
`endif
        output interval_code, remaining, busy, expired
    );

    modport master (
        output start_timer, interval_req, prog_sync, value,
`ifdef TIMER_PAUSE_EN
        output pause,
`endif
        input  interval_code, remaining, busy, expired
    );
endinterface

// File: rtl/interval_countdown.sv
// interval_countdown: fetches an interval length (seconds) from the
// time-parameter store, counts it down on a prescaled one-second tick and
// pulses expired for one cycle when the count reaches zero.
// prog_sync aborts any fetch/count in progress because stored parameters
// may be changing underneath us. Optional macro TIMER_PAUSE_EN adds a pause
// input that freezes the countdown while in COUNT.
module interval_countdown #(
    parameter int VALUE_W  = 4,
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    interval_countdown_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic [VALUE_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               busy_q, busy_d;
    logic               expired_q, expired_d;
    logic               tick;
    logic               hold;
    logic               startReq;

`ifdef TIMER_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif

    assign tick     = (presc_q == DIV_W'(TICK_DIV - 1));
    assign startReq = bus.start_timer && !bus.prog_sync;

    // Next-state and datapath decode; prog_sync always outranks start_timer,
    // and a restart in COUNT wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        unique case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d = FETCH;
                    code_d  = bus.interval_req;
                end
            end
            FETCH: begin
                presc_d = '0;
                if (bus.prog_sync) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    rem_d   = bus.value;
                    state_d = (bus.value == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (bus.prog_sync) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    presc_d = '0;
                end else if (bus.start_timer) begin
                    state_d = FETCH;
                    code_d  = bus.interval_req;
                end else if (!hold) begin
                    if (tick) begin
                        presc_d = '0;
                        if (rem_q <= VALUE_W'(1)) begin
                            rem_d   = '0;
                            state_d = DONE;
                        end else begin
                            rem_d = rem_q - VALUE_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
            end
            DONE: begin
                if (startReq) begin
                    state_d = FETCH;
                    code_d  = bus.interval_req;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d == FETCH) || (state_d == COUNT);
        expired_d = (state_d == DONE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= 2'b00;
            rem_q     <= '0;
            presc_q   <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            rem_q     <= rem_d;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign bus.interval_code = code_q;
    assign bus.remaining     = rem_q;
    assign bus.busy          = busy_q;
    assign bus.expired       = expired_q;

endmodule

// File: tb/tb_interval_countdown.sv
// tb_interval_countdown: directed scenarios for interval_countdown with
// hand-computed cycle counts (TICK_DIV = 10). Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point.
module tb_interval_countdown;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    interval_countdown_if #(.VALUE_W(4)) bus ();

    interval_countdown #(
        .VALUE_W (4),
        .TICK_DIV(10),
        .DIV_W   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start_timer  = 1'b0;
        bus.interval_req = 2'b11;
        bus.prog_sync    = 1'b0;
        bus.value        = 4'd9;
`ifdef TIMER_PAUSE_EN
        bus.pause        = 1'b0;
`endif
        rst_n = 1'b0;
        step(2);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.expired !== 1'b0) begin fails++; $display("[TB] FAIL rst_expired: got %b expected 0", bus.expired); end
        checks++; if (bus.remaining !== 4'd0) begin fails++; $display("[TB] FAIL rst_remaining: got %0d expected 0", bus.remaining); end
        checks++; if (bus.interval_code !== 2'b00) begin fails++; $display("[TB] FAIL rst_code: got %b expected 00", bus.interval_code); end
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.interval_code !== 2'b00) begin fails++; $display("[TB] FAIL post_rst_code_held: got %b expected 00", bus.interval_code); end
    endtask

    task automatic test_basic();
        int early = 0;
        bus.interval_req = 2'b10;
        bus.value        = 4'd13;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        checks++; if (bus.interval_code !== 2'b10) begin fails++; $display("[TB] FAIL basic_code: got %b expected 10", bus.interval_code); end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_fetch: got %b expected 1", bus.busy); end
        step(1);
        checks++; if (bus.remaining !== 4'd13) begin fails++; $display("[TB] FAIL basic_load: got %0d expected 13", bus.remaining); end
        for (int k = 1; k <= 130; k++) begin
            step(1);
            if (k < 130 && bus.expired !== 1'b0) early++;
            if (k == 10) begin
                checks++; if (bus.remaining !== 4'd12) begin fails++; $display("[TB] FAIL basic_first_tick: got %0d expected 12", bus.remaining); end
            end
            if (k == 129) begin
                checks++; if (bus.remaining !== 4'd1) begin fails++; $display("[TB] FAIL basic_last_second: got %0d expected 1", bus.remaining); end
            end
        end
        checks++; if (early !== 0) begin fails++; $display("[TB] FAIL basic_early_expired: got %0d cycles expected 0", early); end
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL basic_expired_130: got %b expected 1", bus.expired); end
        checks++; if (bus.remaining !== 4'd0) begin fails++; $display("[TB] FAIL basic_remaining_end: got %0d expected 0", bus.remaining); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_done: got %b expected 0", bus.busy); end
        step(1);
        checks++; if (bus.expired !== 1'b0) begin fails++; $display("[TB] FAIL basic_pulse_width: got %b expected 0", bus.expired); end
    endtask

    task automatic test_zero();
        bus.interval_req = 2'b00;
        bus.value        = 4'd0;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL zero_busy_fetch: got %b expected 1", bus.busy); end
        step(1);
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL zero_expired: got %b expected 1", bus.expired); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy_done: got %b expected 0", bus.busy); end
        step(1);
        checks++; if (bus.expired !== 1'b0) begin fails++; $display("[TB] FAIL zero_pulse_width: got %b expected 0", bus.expired); end
    endtask

    task automatic test_abort();
        int seen = 0;
        bus.interval_req = 2'b00;
        bus.value        = 4'd5;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(1);
        step(23);
        checks++; if (bus.remaining !== 4'd3) begin fails++; $display("[TB] FAIL abort_pre_remaining: got %0d expected 3", bus.remaining); end
        bus.prog_sync = 1'b1;
        step(1);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.remaining !== 4'd0) begin fails++; $display("[TB] FAIL abort_remaining: got %0d expected 0", bus.remaining); end
        bus.prog_sync = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.expired !== 1'b0) seen++;
            step(1);
        end
        checks++; if (seen !== 0) begin fails++; $display("[TB] FAIL abort_no_expired: got %0d cycles expected 0", seen); end
    endtask

    task automatic test_restart();
        int early = 0;
        bus.interval_req = 2'b00;
        bus.value        = 4'd5;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(1);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (bus.expired !== 1'b0) early++;
        end
        checks++; if (bus.remaining !== 4'd2) begin fails++; $display("[TB] FAIL restart_pre_remaining: got %0d expected 2", bus.remaining); end
        bus.interval_req = 2'b01;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        bus.value       = 4'd3;
        checks++; if (bus.interval_code !== 2'b01) begin fails++; $display("[TB] FAIL restart_code: got %b expected 01", bus.interval_code); end
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL restart_busy: got %b expected 1", bus.busy); end
        step(1);
        checks++; if (bus.remaining !== 4'd3) begin fails++; $display("[TB] FAIL restart_load: got %0d expected 3", bus.remaining); end
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k < 30 && bus.expired !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin fails++; $display("[TB] FAIL restart_stale_expired: got %0d cycles expected 0", early); end
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL restart_expired_30: got %b expected 1", bus.expired); end
        step(1);
    endtask

    task automatic test_back_to_back();
        bus.interval_req = 2'b00;
        bus.value        = 4'd2;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(1);
        step(20);
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL b2b_first_expired: got %b expected 1", bus.expired); end
        bus.interval_req = 2'b10;
        bus.value        = 4'd1;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_direct_fetch: got %b expected 1", bus.busy); end
        checks++; if (bus.interval_code !== 2'b10) begin fails++; $display("[TB] FAIL b2b_code: got %b expected 10", bus.interval_code); end
        checks++; if (bus.expired !== 1'b0) begin fails++; $display("[TB] FAIL b2b_pulse_width: got %b expected 0", bus.expired); end
        step(1);
        checks++; if (bus.remaining !== 4'd1) begin fails++; $display("[TB] FAIL b2b_load: got %0d expected 1", bus.remaining); end
        step(10);
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL b2b_second_expired: got %b expected 1", bus.expired); end
        step(1);
    endtask

    task automatic test_priority();
        bus.interval_req = 2'b01;
        bus.start_timer  = 1'b1;
        bus.prog_sync    = 1'b1;
        step(1);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL prio_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.interval_code !== 2'b10) begin fails++; $display("[TB] FAIL prio_code_held: got %b expected 10", bus.interval_code); end
        bus.start_timer = 1'b0;
        bus.prog_sync   = 1'b0;
        step(1);
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic test_pause();
        int early = 0;
        bus.interval_req = 2'b00;
        bus.value        = 4'd2;
        bus.start_timer  = 1'b1;
        step(1);
        bus.start_timer = 1'b0;
        step(1);
        step(5);
        bus.pause = 1'b1;
        step(7);
        checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL pause_busy: got %b expected 1", bus.busy); end
        bus.pause = 1'b0;
        step(4);
        checks++; if (bus.remaining !== 4'd2) begin fails++; $display("[TB] FAIL pause_frozen: got %0d expected 2", bus.remaining); end
        for (int k = 17; k <= 27; k++) begin
            step(1);
            if (k < 27 && bus.expired !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin fails++; $display("[TB] FAIL pause_early_expired: got %0d cycles expected 0", early); end
        checks++; if (bus.expired !== 1'b1) begin fails++; $display("[TB] FAIL pause_expired_27: got %b expected 1", bus.expired); end
        step(1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_restart();
        test_back_to_back();
        test_priority();
`ifdef TIMER_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/interval_countdown.md
Name: interval_countdown

Overview:
- Consumer side of the time-parameter store: on a start request, drives interval_code to the store, samples the returned value (seconds), and counts it down on an internal prescaled tick.
- Asserts a one-cycle expired pulse when the count reaches zero.
- Sits between the traffic-light FSM (start_timer/expired) and time_parameter (interval_code/value).
- Honours prog_sync as an abort, because stored parameters may change mid-count.

Parameters:
- VALUE_W, 4, width of value/remaining (seconds).
- TICK_DIV, 10, clk cycles per one-second tick (simulation default; silicon sets the real clock rate).
- DIV_W, 4, prescaler width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- start_timer  in  1  level sampled each edge; 1 starts or restarts a countdown.
- interval_req  in  2  interval wanted by controller (00 base, 01 extended, 10 yellow, 11 base); sampled with start_timer.
- prog_sync  in  1  parameter reprogram in progress; aborts a countdown.
- value  in  VALUE_W  interval length returned by time_parameter.
- interval_code  out  2  code presented to time_parameter.
- remaining  out  VALUE_W  seconds left (registered).
- busy  out  1  high in FETCH or COUNT.
- expired  out  1  one-cycle pulse at end of countdown.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, interval_code=00, remaining=0, prescaler=0, busy=0, expired=0.
  - Deassertion takes effect at the next clk edge.
- States: IDLE, FETCH, COUNT, DONE. All outputs are registered; expired==(state==DONE), busy==(state in FETCH,COUNT).
- IDLE:
  - start_timer=1 and prog_sync=0 at edge E0 -> FETCH, interval_code<=interval_req.
  - Otherwise stay in IDLE, holding interval_code.
- FETCH:
  - One cycle, so the registered read from time_parameter settles.
  - At E1: remaining<=value, prescaler<=0.
  - value==0 -> DONE; else -> COUNT.
- COUNT:
  - prescaler increments each cycle; tick = (prescaler==TICK_DIV-1).
  - On tick: prescaler<=0, remaining<=remaining-1.
  - tick with remaining==1 -> remaining<=0, go to DONE.
  - Expired pulse occurs value*TICK_DIV cycles after E1 (E1 is the end of FETCH).
- DONE:
  - expired=1 for exactly one cycle, then IDLE.
  - start_timer=1 in DONE -> FETCH directly (back-to-back intervals, no idle gap).
- Restart: start_timer=1 while in COUNT -> FETCH with the new interval_req. Prescaler and remaining are reloaded and no expired is issued for the abandoned count.
- Abort: prog_sync=1 in FETCH/COUNT -> IDLE next edge, remaining<=0, no expired.
- Priority: prog_sync beats start_timer in all states; start_timer is ignored while prog_sync=1.
- remaining never wraps below 0. value is treated as unsigned, maximum 2^VALUE_W-1.
- Reset asserted mid-count clears everything immediately (asynchronously); no expired is generated.

Optional Feature:
- Macro TIMER_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - pause=1 in COUNT freezes prescaler and remaining; state stays COUNT; busy stays 1.
  - prog_sync and start_timer still act while paused.
- Undefined: no pause port; countdown is never frozen.

Test Plan:
- Reset low 2 cycles, release -> all outputs 0, state IDLE, interval_code=00.
- interval_req=10, value=13, start_timer pulse -> interval_code=10 next cycle; remaining=13 after FETCH; expired pulse for 1 cycle exactly 130 cycles after FETCH edge; remaining=0.
- Start with value=0 -> expired on the edge after FETCH; busy high only during FETCH.
- Start with value=5; prog_sync=1 after 23 cycles of COUNT -> IDLE next edge, remaining=0, expired never asserted.
- value=5, restart with interval_req=01/value=3 at 30 cycles into COUNT -> expired exactly 30 cycles after the second FETCH; no pulse at the original 50.
- TIMER_PAUSE_EN defined, value=2, pause=1 for 7 cycles mid-count -> expired delayed by exactly 7 cycles (27 after FETCH).
